// File: rtl/muxnto1_rr_if.sv
// Handshake bundle for the N-channel result-select mux: per-channel inputs with valid/ready,
// a registered output beat with valid/ready, and the fixed/round-robin select controls.
interface muxnto1_rr_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       d_valid;
    logic [CHANNELS-1:0]       d_ready;
    logic [SEL_W-1:0]          s;
    logic                      rr_en;
    logic [WIDTH-1:0]          f;
    logic [SEL_W-1:0]          f_chan;
    logic                      f_valid;
    logic                      f_ready;

    modport master (
        output d, d_valid, s, rr_en, f_ready,
        input  d_ready, f, f_chan, f_valid
    );

    modport slave (
        input  d, d_valid, s, rr_en, f_ready,
        output d_ready, f, f_chan, f_valid
    );
endinterface

// File: rtl/muxnto1_rr.sv
// Registered N:1 result-select mux, fixed select or round-robin; 1-cycle latency.
// Backpressure: d_ready is granted only when the output register is empty or draining.
module muxnto1_rr #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    muxnto1_rr_if.slave  bus
);
    logic                load;
    logic                gnt_vld;
    logic [SEL_W-1:0]    gnt;
    logic [SEL_W-1:0]    ptr;
    logic [WIDTH-1:0]    sel_dat;
    logic [CHANNELS-1:0] ready;
    int                  idx;

    assign load = !bus.f_valid || bus.f_ready;

    // Round-robin searches from the channel after the last one granted, wrapping at CHANNELS.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        if (!bus.rr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.s == SEL_W'(i) && bus.d_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = (int'(ptr) + k) % CHANNELS;
                if (!gnt_vld && bus.d_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt == SEL_W'(i)) sel_dat = bus.d[i*WIDTH +: WIDTH];
        end
    end

    // No channel is offered ready while reset is held, so nothing is consumed and dropped.
    always_comb begin
        ready = '0;
        if (rst_n && gnt_vld && load) ready[gnt] = 1'b1;
    end

    assign bus.d_ready = ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.f       <= '0;
            bus.f_chan  <= '0;
            bus.f_valid <= 1'b0;
            ptr         <= SEL_W'(CHANNELS - 1);
        end else if (gnt_vld && load) begin
            bus.f       <= sel_dat;
            bus.f_chan  <= gnt;
            bus.f_valid <= 1'b1;
            if (bus.rr_en) ptr <= gnt;
        end else if (bus.f_ready) begin
            bus.f_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_muxnto1_rr.sv
// Bench for muxnto1_rr: directed scenarios plus randomized traffic against a behavioural model.
module tb_muxnto1_rr;
    localparam int W  = 32;
    localparam int C  = 8;
    localparam int SW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muxnto1_rr_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW)) bus ();
    muxnto1_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    // Model state: output register contents and the last round-robin winner.
    logic [W-1:0]  m_f    = '0;
    logic [SW-1:0] m_chan = '0;
    logic          m_vld  = 1'b0;
    int            m_ptr  = C - 1;
    int            sent[C];
    int            recv[C];

    function automatic int exp_grant();
        if (!bus.rr_en)
            return (int'(bus.s) < C && bus.d_valid[bus.s]) ? int'(bus.s) : -1;
        for (int k = 1; k <= C; k++) begin
            int c;
            c = (m_ptr + k) % C;
            if (bus.d_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [C-1:0] exp_ready();
        logic [C-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (rst_n && g >= 0 && (!m_vld || bus.f_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        int g;
        logic ld, rr;
        logic [W-1:0] dg;
        #1;
        g  = exp_grant();
        ld = !m_vld || bus.f_ready;
        rr = bus.rr_en;
        dg = (g >= 0) ? bus.d[g*W +: W] : '0;
        for (int c = 0; c < C; c++)
            if (bus.d_valid[c] && bus.d_ready[c]) sent[c]++;
        if (rst_n && bus.f_valid === 1'b1 && bus.f_ready) recv[bus.f_chan]++;
        @(posedge clk);
        if (!rst_n) begin
            m_f = '0; m_chan = '0; m_vld = 1'b0; m_ptr = C - 1;
        end else if (g >= 0 && ld) begin
            m_f = dg; m_chan = SW'(g); m_vld = 1'b1;
            if (rr) m_ptr = g;
        end else if (m_vld && bus.f_ready) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int c = 0; c < C; c++) bus.d[c*W +: W] = $urandom();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rand_data();
        bus.d_valid = '1; bus.rr_en = 1'b1; bus.f_ready = 1'b1; bus.s = '0;
        rst_n = 1'b0;
        tick(); tick();
        #1;
        vectors++;
        if (bus.f !== '0 || bus.f_chan !== '0 || bus.f_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got f=%h chan=%0d vld=%b required 0/0/0", bus.f, bus.f_chan, bus.f_valid);
        end
        vectors++;
        if (bus.d_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_d_ready: got %h required 00", bus.d_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.d_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %h required 01", bus.d_ready);
        end
        tick();
        vectors++;
        if (bus.f_chan !== 3'd0 || bus.f_valid !== 1'b1 || bus.f !== m_f) begin
            miscompares++;
            $display("FAIL reset_first_beat: got chan=%0d vld=%b f=%h required 0/1/%h", bus.f_chan, bus.f_valid, bus.f, m_f);
        end
    endtask

    task automatic test_fixed();
        rand_data();
        bus.d[5*W +: W] = 32'hDEADBEEF;
        bus.rr_en = 1'b0; bus.s = 3'd5; bus.d_valid = 8'hFF; bus.f_ready = 1'b1;
        #1;
        vectors++;
        if (bus.d_ready !== 8'h20) begin
            miscompares++;
            $display("FAIL fixed_d_ready: got %h required 20", bus.d_ready);
        end
        tick();
        vectors++;
        if (bus.f !== 32'hDEADBEEF || bus.f_chan !== 3'd5 || bus.f_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_beat: got f=%h chan=%0d vld=%b required deadbeef/5/1", bus.f, bus.f_chan, bus.f_valid);
        end
        bus.d_valid = 8'hDF;
        #1;
        vectors++;
        if (bus.d_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL fixed_no_grant: got %h required 00", bus.d_ready);
        end
        tick();
        vectors++;
        if (bus.f_valid !== 1'b0 || bus.f !== 32'hDEADBEEF || bus.f_chan !== 3'd5) begin
            miscompares++;
            $display("FAIL fixed_drain: got vld=%b f=%h chan=%0d required 0/deadbeef/5", bus.f_valid, bus.f, bus.f_chan);
        end
    endtask

    task automatic test_rr_fair();
        do_reset();
        bus.rr_en = 1'b1; bus.d_valid = 8'hFF; bus.f_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            tick();
            vectors++;
            if (bus.f_chan !== SW'(i % C) || bus.f_valid !== 1'b1 || bus.f !== m_f) begin
                miscompares++;
                $display("FAIL rr_all_%0d: got chan=%0d vld=%b f=%h required %0d/1/%h", i, bus.f_chan, bus.f_valid, bus.f, i % C, m_f);
            end
        end
        bus.d_valid = 8'h81;
        for (int i = 0; i < 4; i++) begin
            logic [SW-1:0] e;
            e = (i % 2 == 0) ? 3'd0 : 3'd7;
            tick();
            vectors++;
            if (bus.f_chan !== e || bus.f_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_81_%0d: got chan=%0d vld=%b required %0d/1", i, bus.f_chan, bus.f_valid, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  hold_f;
        logic [SW-1:0] hold_c;
        do_reset();
        rand_data();
        bus.rr_en = 1'b1; bus.d_valid = 8'hFF; bus.f_ready = 1'b1;
        tick();
        hold_f = bus.f; hold_c = bus.f_chan;
        bus.f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            vectors++;
            if (bus.d_ready !== 8'h00) begin
                miscompares++;
                $display("FAIL stall_d_ready_%0d: got %h required 00", i, bus.d_ready);
            end
            tick();
            vectors++;
            if (bus.f !== hold_f || bus.f_chan !== hold_c || bus.f_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got f=%h chan=%0d vld=%b required %h/%0d/1", i, bus.f, bus.f_chan, bus.f_valid, hold_f, hold_c);
            end
        end
        bus.f_ready = 1'b1;
        #1;
        vectors++;
        if (bus.d_ready !== exp_ready() || bus.d_ready === 8'h00) begin
            miscompares++;
            $display("FAIL stall_release: got %h required %h", bus.d_ready, exp_ready());
        end
        tick();
        vectors++;
        if (bus.f !== m_f || bus.f_chan !== m_chan || bus.f_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_beat: got f=%h chan=%0d required %h/%0d", bus.f, bus.f_chan, m_f, m_chan);
        end

        bus.d_valid = '0;
        tick();
        for (int c = 0; c < C; c++) begin sent[c] = 0; recv[c] = 0; end
        for (int n = 0; n < 300; n++) begin
            rand_data();
            bus.d_valid = 8'($urandom()) & 8'($urandom());
            bus.s       = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) bus.rr_en = ~bus.rr_en;
            bus.f_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (bus.d_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rand_d_ready_%0d: got %h required %h", n, bus.d_ready, exp_ready());
            end
            tick();
            vectors++;
            if (bus.f !== m_f || bus.f_chan !== m_chan || bus.f_valid !== m_vld) begin
                miscompares++;
                $display("FAIL rand_out_%0d: got f=%h chan=%0d vld=%b required %h/%0d/%b", n, bus.f, bus.f_chan, bus.f_valid, m_f, m_chan, m_vld);
            end
        end
        bus.d_valid = '0; bus.f_ready = 1'b1;
        tick(); tick();
        for (int c = 0; c < C; c++) begin
            vectors++;
            if (sent[c] !== recv[c] || (c == 0 && sent[c] == 0)) begin
                miscompares++;
                $display("FAIL scoreboard_ch%0d: delivered %0d accepted %0d", c, recv[c], sent[c]);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        rand_data();
        bus.rr_en = 1'b1; bus.d_valid = 8'h40; bus.f_ready = 1'b1;
        #1;
        vectors++;
        if (bus.d_ready !== 8'h40) begin
            miscompares++;
            $display("FAIL mode_rr6: got %h required 40", bus.d_ready);
        end
        tick();
        bus.rr_en = 1'b0; bus.s = 3'd2; bus.d_valid = 8'hFF;
        tick(); tick();
        vectors++;
        if (bus.f_chan !== 3'd2 || bus.f_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_fixed2: got chan=%0d vld=%b required 2/1", bus.f_chan, bus.f_valid);
        end
        bus.rr_en = 1'b1;
        #1;
        vectors++;
        if (bus.d_ready !== 8'h80) begin
            miscompares++;
            $display("FAIL mode_back_rr: got %h required 80", bus.d_ready);
        end
        tick();
        vectors++;
        if (bus.f_chan !== 3'd7) begin
            miscompares++;
            $display("FAIL mode_chan7: got %0d required 7", bus.f_chan);
        end
        tick();
        vectors++;
        if (bus.f_chan !== 3'd0 || bus.f !== m_f) begin
            miscompares++;
            $display("FAIL mode_wrap0: got chan=%0d f=%h required 0/%h", bus.f_chan, bus.f, m_f);
        end
    endtask

    task automatic test_mid_reset();
        rand_data();
        bus.rr_en = 1'b1; bus.d_valid = 8'hFF; bus.f_ready = 1'b1;
        tick(); tick();
        bus.f_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        #1;
        vectors++;
        if (bus.f !== '0 || bus.f_chan !== '0 || bus.f_valid !== 1'b0 || bus.d_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_outputs: got f=%h chan=%0d vld=%b rdy=%h required 0/0/0/00", bus.f, bus.f_chan, bus.f_valid, bus.d_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.d_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL midreset_restart: got %h required 01", bus.d_ready);
        end
        tick();
        vectors++;
        if (bus.f_chan !== 3'd0 || bus.f_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_beat: got chan=%0d vld=%b required 0/1", bus.f_chan, bus.f_valid);
        end
    endtask

    initial begin
        bus.d = '0; bus.d_valid = '0; bus.s = '0; bus.rr_en = 1'b1; bus.f_ready = 1'b1;
        for (int c = 0; c < C; c++) begin sent[c] = 0; recv[c] = 0; end
        @(negedge clk);
        test_reset();
        test_fixed();
        test_rr_fair();
        test_backpressure();
        test_mode_switch();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
